// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and default widths for the sweep sequencer
package sweep_pkg;

   localparam int CW_DEF = 8;
   localparam int RW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/updown_cnt_en.sv
// rtl/updown_cnt_en.sv - W-bit counter with synchronous load, enable and direction
module updown_cnt_en #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic         i_up,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Load has priority over counting so a new sweep always starts from lo.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_en) begin
         r_q <= i_up ? (r_q + W'(1)) : (r_q - W'(1));
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - triangle-sweep sequencer between lo/hi limits for a set number of periods
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] lo,
   input  logic [CW-1:0] hi,
   input  logic [RW-1:0] reps,
   output logic [CW-1:0] c_out,
   output logic          dir,
   output logic          busy,
   output logic          done,
   output logic          err
);

   sweep_state_t  r_state, w_state_nx;
   logic [CW-1:0] r_lo, r_hi, w_lo_nx, w_hi_nx;
   logic [RW-1:0] r_reps, r_rep_cnt, w_reps_nx, w_rep_cnt_nx;
   logic          r_dir, r_busy, r_done, r_err;
   logic          w_dir_nx, w_busy_nx, w_done_nx, w_err_nx;
   logic          w_load, w_en, w_up;
   logic [CW-1:0] w_cnt;
   logic [CW-1:0] w_c_inc, w_c_dec;
   logic [RW-1:0] w_rep_inc;

   assign w_c_inc   = w_cnt + CW'(1);
   assign w_c_dec   = w_cnt - CW'(1);
   assign w_rep_inc = r_rep_cnt + RW'(1);

   updown_cnt_en #(.W(CW)) u_cnt (
      .clk        (clk),
      .resetn     (resetn),
      .i_load     (w_load),
      .i_load_val (lo),
      .i_en       (w_en),
      .i_up       (w_up),
      .o_q        (w_cnt)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_lo      <= '0;
         r_hi      <= '0;
         r_reps    <= '0;
         r_rep_cnt <= '0;
         r_dir     <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_lo      <= w_lo_nx;
         r_hi      <= w_hi_nx;
         r_reps    <= w_reps_nx;
         r_rep_cnt <= w_rep_cnt_nx;
         r_dir     <= w_dir_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
         r_err     <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_lo_nx      = r_lo;
      w_hi_nx      = r_hi;
      w_reps_nx    = r_reps;
      w_rep_cnt_nx = r_rep_cnt;
      w_dir_nx     = r_dir;
      w_busy_nx    = r_busy;
      w_done_nx    = 1'b0;
      w_err_nx     = 1'b0;
      w_load       = 1'b0;
      w_en         = 1'b0;
      w_up         = 1'b1;

      case (r_state)
         IDLE: begin
            // abort outranks start, so a rejected start under abort raises no err either
            if (start && !abort) begin
               if (lo < hi) begin
                  w_lo_nx      = lo;
                  w_hi_nx      = hi;
                  w_reps_nx    = reps;
                  w_rep_cnt_nx = '0;
                  w_load       = 1'b1;
                  w_dir_nx     = 1'b1;
                  w_busy_nx    = 1'b1;
                  w_state_nx   = UP;
               end else begin
                  w_err_nx = 1'b1;
               end
            end
         end
         UP: begin
            if (abort) begin
               w_state_nx = IDLE;
               w_busy_nx  = 1'b0;
               w_dir_nx   = 1'b1;
            end else begin
               w_en = 1'b1;
               w_up = 1'b1;
               if (w_c_inc == r_hi) begin
                  w_dir_nx   = 1'b0;
                  w_state_nx = DOWN;
               end
            end
         end
         DOWN: begin
            if (abort) begin
               w_state_nx = IDLE;
               w_busy_nx  = 1'b0;
               w_dir_nx   = 1'b1;
            end else begin
               w_en = 1'b1;
               w_up = 1'b0;
               if (w_c_dec == r_lo) begin
                  w_rep_cnt_nx = w_rep_inc;
                  w_dir_nx     = 1'b1;
                  // reps of zero never matches here, giving continuous mode
                  if ((r_reps != '0) && (w_rep_inc == r_reps)) begin
                     w_state_nx = IDLE;
                     w_busy_nx  = 1'b0;
                     w_done_nx  = 1'b1;
                  end else begin
                     w_state_nx = UP;
                  end
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_busy_nx  = 1'b0;
            w_dir_nx   = 1'b1;
         end
      endcase
   end

   assign c_out = w_cnt;
   assign dir   = r_dir;
   assign busy  = r_busy;
   assign done  = r_done;
   assign err   = r_err;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - directed bench for sweep_ctrl with a closed-form per-cycle reference model
module tb_sweep_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] lo = '0;
   logic [7:0] hi = '0;
   logic [7:0] reps = '0;
   logic [7:0] c_out;
   logic       dir, busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   sweep_ctrl #(.CW(8), .RW(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .abort  (abort),
      .lo     (lo),
      .hi     (hi),
      .reps   (reps),
      .c_out  (c_out),
      .dir    (dir),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: position inside the sweep is a function of edges elapsed since start.
   logic       m_act, m_busy, m_dir, m_done, m_err;
   logic [7:0] m_c;
   int         m_k, m_lo, m_hi, m_reps;

   always @(posedge clk or negedge resetn) begin
      int span, per, ph;
      if (!resetn) begin
         m_act = 0; m_busy = 0; m_dir = 1; m_done = 0; m_err = 0;
         m_c = 0; m_k = 0; m_lo = 0; m_hi = 0; m_reps = 0;
      end else begin
         m_done = 0;
         m_err  = 0;
         if (m_act) begin
            if (abort) begin
               m_act = 0; m_busy = 0; m_dir = 1;
            end else begin
               m_k++;
               span = m_hi - m_lo;
               per  = 2 * span;
               ph   = m_k % per;
               m_c  = (ph <= span) ? 8'(m_lo + ph) : 8'(m_hi - (ph - span));
               m_dir = (ph < span);
               if (m_reps != 0 && m_k == m_reps * per) begin
                  m_act = 0; m_busy = 0; m_done = 1; m_dir = 1;
               end
            end
         end else if (start && !abort) begin
            if (lo < hi) begin
               m_lo = lo; m_hi = hi; m_reps = reps; m_k = 0;
               m_act = 1; m_busy = 1; m_c = lo; m_dir = 1;
            end else begin
               m_err = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         check("model c_out", c_out, m_c);
         check("model dir",   dir,   m_dir);
         check("model busy",  busy,  m_busy);
         check("model done",  done,  m_done);
         check("model err",   err,   m_err);
         n_checks++;
         if (done && err) begin
            n_fail++;
            $display("FAIL done_err_overlap: got done=1 err=1, expected not both");
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [7:0] l, input logic [7:0] h, input logic [7:0] r);
      lo = l; hi = h; reps = r;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_c[7];
      logic       exp_d[7];
      int bc, dc, mx, mn, guard;

      exp_c[0] = 2; exp_c[1] = 3; exp_c[2] = 4; exp_c[3] = 5;
      exp_c[4] = 4; exp_c[5] = 3; exp_c[6] = 2;
      exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 1; exp_d[3] = 0;
      exp_d[4] = 0; exp_d[5] = 0; exp_d[6] = 1;

      #12;
      check("reset c_out", c_out, 0);
      check("reset dir",   dir,   1);
      check("reset busy",  busy,  0);
      check("reset done",  done,  0);
      check("reset err",   err,   0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick();

      // single period 2..5..2
      go(8'd2, 8'd5, 8'd1);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("single c_out[%0d]", i), c_out, exp_c[i]);
         check($sformatf("single dir[%0d]", i),   dir,   exp_d[i]);
         check($sformatf("single busy[%0d]", i),  busy,  (i < 6) ? 1 : 0);
         check($sformatf("single done[%0d]", i),  done,  (i == 6) ? 1 : 0);
         if (i < 6) tick();
      end

      // restart on the cycle after done, minimal span hi-lo==1
      go(8'd2, 8'd3, 8'd1);
      check("span1 c0", c_out, 2);
      check("span1 busy0", busy, 1);
      tick();
      check("span1 c1", c_out, 3);
      check("span1 dir1", dir, 0);
      tick();
      check("span1 c2", c_out, 2);
      check("span1 done", done, 1);
      check("span1 busy2", busy, 0);
      tick();

      // full range, two periods
      go(8'd0, 8'd255, 8'd2);
      bc = 0; dc = 0; mx = 0; mn = 255; guard = 0;
      while (busy && guard < 3000) begin
         bc++;
         if (done) dc++;
         if (c_out > mx) mx = c_out;
         if (c_out < mn) mn = c_out;
         tick();
         guard++;
      end
      check("full busy cycles", bc, 1020);
      check("full max", mx, 255);
      check("full min", mn, 0);
      check("full early done", dc, 0);
      check("full done", done, 1);
      check("full final c_out", c_out, 0);
      tick();
      check("full done clears", done, 0);

      // rejected starts
      go(8'd7, 8'd7, 8'd1);
      check("rej1 err", err, 1);
      check("rej1 busy", busy, 0);
      check("rej1 c_out", c_out, 0);
      tick();
      check("rej1 err clears", err, 0);
      go(8'd9, 8'd3, 8'd1);
      check("rej2 err", err, 1);
      check("rej2 busy", busy, 0);
      check("rej2 c_out", c_out, 0);
      tick();

      // continuous 10..12, abort at 11 descending in the fourth period
      go(8'd10, 8'd12, 8'd0);
      repeat (15) tick();
      check("cont c_out", c_out, 11);
      check("cont dir", dir, 0);
      check("cont busy", busy, 1);
      abort = 1'b1;
      start = 1'b1;
      tick();
      check("abort busy", busy, 0);
      check("abort c_out", c_out, 11);
      check("abort dir", dir, 1);
      check("abort done", done, 0);
      tick();
      check("abort+start busy", busy, 0);
      check("abort+start c_out", c_out, 11);
      abort = 1'b0;
      start = 1'b0;
      tick();
      check("post abort busy", busy, 0);

      // inputs changed and start pulsed mid-sweep are ignored
      go(8'd1, 8'd4, 8'd1);
      bc = 0; guard = 0;
      while (busy && guard < 100) begin
         bc++;
         if (bc == 3) begin
            lo = 8'd0; hi = 8'd9; reps = 8'd5; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         guard++;
      end
      start = 1'b0;
      check("ignore busy cycles", bc, 6);
      check("ignore done", done, 1);
      check("ignore c_out", c_out, 1);
      tick();

      // asynchronous reset mid-sweep
      go(8'd2, 8'd6, 8'd0);
      repeat (3) tick();
      #2;
      resetn = 1'b0;
      #1;
      check("async rst c_out", c_out, 0);
      check("async rst dir", dir, 1);
      check("async rst busy", busy, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick();
      check("idle after rst busy", busy, 0);
      go(8'd1, 8'd3, 8'd1);
      bc = 0; guard = 0;
      while (busy && guard < 100) begin
         bc++;
         tick();
         guard++;
      end
      check("post rst busy cycles", bc, 4);
      check("post rst done", done, 1);
      check("post rst c_out", c_out, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Triangle-sweep sequencer built around a parameterised up/down counter. It steps a CW-bit count from a programmable low limit up to a high limit and back, for a programmed number of periods or continuously, and drives the count direction itself. It sits between a register/config interface (start/abort, limits, repeat count) and any consumer of a ramp value, such as a PWM compare, DAC code or address sweep.

## Interface
- CW, default 8: count width; c_out, lo and hi are CW bits.
- RW, default 8: repeat-count width.

- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  stop immediately; sampled in every state; has priority over start.
- lo  in  CW  lower limit; latched on accepted start.
- hi  in  CW  upper limit; latched on accepted start.
- reps  in  RW  number of full periods; 0 means continuous. Latched on accepted start.
- c_out  out  CW  current sweep value (registered).
- dir  out  1  current direction: 1 = up, 0 = down (registered).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the final period completes.
- err  out  1  one-cycle pulse when a start is rejected because lo >= hi.

## Operation
- States: IDLE, UP, DOWN.
- Reset values (asynchronous): state IDLE, c_out 0, dir 1, busy 0, done 0, err 0, repeat counter 0, latched limits 0.
- IDLE, start=1, abort=0, lo<hi:
  - latch lo, hi and reps; clear the repeat counter;
  - load c_out<=lo, dir<=1, busy<=1; go to UP.
- IDLE, start=1, lo>=hi: err<=1 for one cycle; stay IDLE; c_out unchanged.
- UP: c_out<=c_out+1. When c_out+1==hi_l, set dir<=0 and go to DOWN.
- DOWN: c_out<=c_out-1. When c_out-1==lo_l, a period ends; the repeat counter increments.
  - If reps_l!=0 and the incremented count equals reps_l: go to IDLE, busy<=0, done<=1, dir<=1.
  - Otherwise: dir<=1 and go to UP.
- Continuous mode (reps_l==0): the repeat counter wraps freely and never terminates the sweep.
- abort in any non-IDLE state: next edge goes to IDLE with busy<=0; c_out holds its last value; dir<=1; no done pulse.
- start while busy: ignored. Changes to lo, hi or reps while busy: ignored; the latched copies are used.
- Arithmetic: c_out stays within [lo_l, hi_l], so no wrap occurs even with hi=2^CW-1 or lo=0. Limit compares are unsigned.
- done and err are never high in the same cycle.

## Timing
- Accepted start at edge t: at that edge c_out=lo and busy=1; the value then changes by 1 on every later edge.
- One period takes 2*(hi-lo) cycles.
- busy is high for exactly reps*2*(hi-lo) cycles.
- c_out returns to lo on the same edge that drops busy and raises done.
- A new start is accepted on the cycle after done.
- hi-lo==1 is legal: the sequence is lo, hi, lo.
- abort at edge t: busy=0 after edge t.
- Simultaneous start and abort in IDLE: abort wins; nothing starts.
- resetn low mid-sweep forces all reset values asynchronously. After release, the block waits in IDLE for start.

## Structure
- Shared package sweep_pkg: state enum (IDLE/UP/DOWN) and default CW/RW constants.
- Sub-module updown_cnt_en: CW-bit counter with synchronous load, enable and direction input. sweep_ctrl instantiates it and drives load/en/dir from the FSM.
- Everything else (FSM, latched limits, repeat counter, compares, pulse outputs) lives in sweep_ctrl.

## Test plan
- Single period: lo=2, hi=5, reps=1, start pulse.
  - c_out must be 2,3,4,5,4,3,2 on consecutive edges; busy high for 6 cycles.
  - done high on the edge where c_out=2 the second time; dir 1,1,1,0,0,0,1.
- Repeat and full range: lo=0, hi=255 (CW=8), reps=2.
  - 1020 busy cycles; no wrap past 255 or below 0.
  - Exactly one done pulse.
- Rejected start: lo=7, hi=7, then lo=9, hi=3.
  - err pulses once for each start; busy stays 0; c_out unchanged.
- Abort and override: continuous mode with lo=10, hi=12; abort when c_out=11 going down.
  - busy drops next edge; c_out holds 11; no done.
  - A start applied together with abort is not accepted.
- Ignored inputs while busy: change lo/hi/reps and pulse start mid-sweep.
  - The sweep continues with the latched values and does not restart.
- Reset mid-sweep: assert resetn low asynchronously between edges.
  - c_out=0, dir=1, busy=0 immediately.
  - After release, a fresh start with lo=1, hi=3, reps=1 completes normally.
